// File: rtl/dec_cfg_pkg.sv
// Shared types and constants for the decoder configuration master.
// Readback verification is enabled by defining DEC_CFG_READBACK_EN.
package dec_cfg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrRam,
        StWrDiv,
        StWrRun,
        StRdRun,
        StRdDiv,
        StFin,
        StWrStop
    } cfg_state_t;

    localparam logic CTL_ADDR_RUN = 1'b0;
    localparam logic CTL_ADDR_DIV = 1'b1;

    localparam logic [1:0] CONTR_RED        = 2'd0;
    localparam logic [1:0] CONTR_YELLOW     = 2'd1;
    localparam logic [1:0] CONTR_RED_YELLOW = 2'd2;
    localparam logic [1:0] CONTR_GREEN      = 2'd3;

    // Per-colour left shift applied to the base period, indexed by contr.
    localparam logic [1:0] SHIFT [4] = '{2'd2, 2'd0, 2'd0, 2'd2};

endpackage

// File: rtl/dec_cfg_if.sv
// Bus bundle between the configuration master and the decoder's control
// and period-RAM slave ports.
interface dec_cfg_if #(
    parameter int unsigned M = 32
);
    logic          ctl_wr;
    logic          ctl_rd;
    logic          ctl_addr;
    logic [31:0]   ctl_wrdata;
    logic [31:0]   ctl_rddata;
    logic          ram_wr;
    logic [3:0]    ram_addr;
    logic [M-1:0]  ram_wrdata;

    modport master (
        output ctl_wr, ctl_rd, ctl_addr, ctl_wrdata, ram_wr, ram_addr, ram_wrdata,
        input  ctl_rddata
    );

    modport slave (
        input  ctl_wr, ctl_rd, ctl_addr, ctl_wrdata, ram_wr, ram_addr, ram_wrdata,
        output ctl_rddata
    );
endinterface

// File: rtl/dec_period_calc.sv
// Combinational period word generator: base_period shifted by the colour's
// shift amount, saturating to all ones when a set bit would be lost.
module dec_period_calc
    import dec_cfg_pkg::*;
#(
    parameter int unsigned M = 32
) (
    input  logic [M-1:0] base_period,
    input  logic [1:0]   c,
    output logic [M-1:0] word
);

    logic [1:0]   sh;
    logic [M-1:0] shifted;

    always_comb begin
        sh      = SHIFT[c];
        shifted = base_period << sh;
        // Shifting back exposes any bits that fell off the top.
        word    = ((shifted >> sh) != base_period) ? '1 : shifted;
    end

endmodule

// File: rtl/dec_cfg_master.sv
// Configuration sequencer for the semaphore decoder: period RAM, divider and
// run registers, with optional readback when DEC_CFG_READBACK_EN is defined.
module dec_cfg_master
    import dec_cfg_pkg::*;
#(
    parameter int unsigned M = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    mode,
    input  logic [M-1:0]  base_period,
    output logic          busy,
    output logic          done,
    output logic          err,
    dec_cfg_if.master     bus
);

    cfg_state_t   state_q, state_d;
    logic [1:0]   c_q, c_d;
    logic [1:0]   mode_q, mode_d;
    logic [M-1:0] base_q, base_d;
    logic         err_q, err_d;

    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         ctl_wr_q, ctl_wr_d;
    logic         ctl_rd_q, ctl_rd_d;
    logic         ctl_addr_q, ctl_addr_d;
    logic [31:0]  ctl_wrdata_q, ctl_wrdata_d;
    logic         ram_wr_q, ram_wr_d;
    logic [3:0]   ram_addr_q, ram_addr_d;
    logic [M-1:0] ram_wrdata_q, ram_wrdata_d;

    logic [M-1:0] word;

    dec_period_calc #(
        .M (M)
    ) u_period_calc (
        .base_period (base_d),
        .c           (c_d),
        .word        (word)
    );

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        mode_d  = mode_q;
        base_d  = base_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (stop) begin
                    state_d = StWrStop;
                end else if (start) begin
                    state_d = StWrRam;
                    c_d     = CONTR_RED;
                    mode_d  = mode;
                    base_d  = base_period;
                    err_d   = 1'b0;
                end
            end
            StWrRam: begin
                if (c_q == CONTR_GREEN) begin
                    state_d = StWrDiv;
                end else begin
                    c_d = c_q + 2'd1;
                end
            end
            StWrDiv: state_d = StWrRun;
`ifdef DEC_CFG_READBACK_EN
            StWrRun: state_d = StRdRun;
`else
            StWrRun: state_d = StFin;
`endif
            StRdRun: begin
                state_d = StRdDiv;
                if (bus.ctl_rddata[0] != 1'b1) err_d = 1'b1;
            end
            StRdDiv: begin
                state_d = StFin;
                if (bus.ctl_rddata[1:0] != mode_q) err_d = 1'b1;
            end
            StFin:    state_d = StIdle;
            StWrStop: state_d = StFin;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in
    // the same cycle the state takes effect.
    always_comb begin
        busy_d       = (state_d != StIdle) && (state_d != StFin);
        done_d       = 1'b0;
        ctl_wr_d     = 1'b0;
        ctl_rd_d     = 1'b0;
        ctl_addr_d   = 1'b0;
        ctl_wrdata_d = '0;
        ram_wr_d     = 1'b0;
        ram_addr_d   = '0;
        ram_wrdata_d = '0;

        unique case (state_d)
            StWrRam: begin
                ram_wr_d     = 1'b1;
                ram_addr_d   = {mode_d, c_d};
                ram_wrdata_d = word;
            end
            StWrDiv: begin
                ctl_wr_d     = 1'b1;
                ctl_addr_d   = CTL_ADDR_DIV;
                ctl_wrdata_d = {30'b0, mode_d};
            end
            StWrRun: begin
                ctl_wr_d     = 1'b1;
                ctl_addr_d   = CTL_ADDR_RUN;
                ctl_wrdata_d = 32'd1;
            end
            StRdRun: begin
                ctl_rd_d   = 1'b1;
                ctl_addr_d = CTL_ADDR_RUN;
            end
            StRdDiv: begin
                ctl_rd_d   = 1'b1;
                ctl_addr_d = CTL_ADDR_DIV;
            end
            StWrStop: begin
                ctl_wr_d     = 1'b1;
                ctl_addr_d   = CTL_ADDR_RUN;
                ctl_wrdata_d = 32'd0;
            end
            StFin:   done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= StIdle;
            c_q          <= '0;
            mode_q       <= '0;
            base_q       <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ctl_wr_q     <= 1'b0;
            ctl_rd_q     <= 1'b0;
            ctl_addr_q   <= 1'b0;
            ctl_wrdata_q <= '0;
            ram_wr_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wrdata_q <= '0;
        end else begin
            state_q      <= state_d;
            c_q          <= c_d;
            mode_q       <= mode_d;
            base_q       <= base_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ctl_wr_q     <= ctl_wr_d;
            ctl_rd_q     <= ctl_rd_d;
            ctl_addr_q   <= ctl_addr_d;
            ctl_wrdata_q <= ctl_wrdata_d;
            ram_wr_q     <= ram_wr_d;
            ram_addr_q   <= ram_addr_d;
            ram_wrdata_q <= ram_wrdata_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign bus.ctl_wr     = ctl_wr_q;
    assign bus.ctl_rd     = ctl_rd_q;
    assign bus.ctl_addr   = ctl_addr_q;
    assign bus.ctl_wrdata = ctl_wrdata_q;
    assign bus.ram_wr     = ram_wr_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wrdata = ram_wrdata_q;

endmodule

// File: tb/tb_dec_cfg_master.sv
// Directed bench for dec_cfg_master with a simple control-slave model.
// Expected done latency follows DEC_CFG_READBACK_EN.
module tb_dec_cfg_master;

`ifdef DEC_CFG_READBACK_EN
    localparam int DONE_CYC = 9;
    localparam int N_RD     = 2;
    localparam logic RB     = 1'b1;
`else
    localparam int DONE_CYC = 7;
    localparam int N_RD     = 0;
    localparam logic RB     = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] base_period = 32'd0;
    logic        busy, done, err;

    dec_cfg_if #(.M(32)) bus ();

    dec_cfg_master #(.M(32)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .base_period (base_period),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Control-slave model; fault_run forces run reads to 0.
    logic [31:0] run_reg, div_reg;
    logic        fault_run = 1'b0;
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            run_reg <= 32'd0;
            div_reg <= 32'd0;
        end else if (bus.ctl_wr) begin
            if (bus.ctl_addr) div_reg <= bus.ctl_wrdata;
            else              run_reg <= bus.ctl_wrdata;
        end
    end
    assign bus.ctl_rddata = bus.ctl_addr ? div_reg : (fault_run ? 32'd0 : run_reg);

    int checks = 0;
    int errors = 0;

    int          n_ram, n_ctl, n_rd, viol, done_cyc;
    logic        err_at_done, busy_at_done, busy_c1, err_c1;
    logic [3:0]  ram_a [8];
    logic [31:0] ram_d [8];
    logic        ctl_a [8];
    logic [31:0] ctl_d [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe max cycles after a request edge; optionally pulse start/stop
    // again during cycle inj so it is seen at the following edge.
    task automatic collect(input int max, input int inj, input logic inj_stop);
        n_ram = 0; n_ctl = 0; n_rd = 0; viol = 0; done_cyc = -1;
        err_at_done = 1'bx; busy_at_done = 1'bx; busy_c1 = 1'bx; err_c1 = 1'bx;
        for (int i = 0; i < 8; i++) begin
            ram_a[i] = '1; ram_d[i] = '1; ctl_a[i] = 1'bx; ctl_d[i] = '1;
        end
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            start = (k == inj);
            stop  = (k == inj) && inj_stop;
            if (k == 1) begin busy_c1 = busy; err_c1 = err; end
            if (int'(bus.ram_wr) + int'(bus.ctl_wr) + int'(bus.ctl_rd) > 1) viol++;
            if (!bus.ram_wr && (bus.ram_addr != 0 || bus.ram_wrdata != 0)) viol++;
            if (!bus.ctl_wr && !bus.ctl_rd && (bus.ctl_addr != 0 || bus.ctl_wrdata != 0)) viol++;
            if (bus.ctl_rd && bus.ctl_wrdata != 0) viol++;
            if (bus.ram_wr) begin
                if (n_ram < 8) begin ram_a[n_ram] = bus.ram_addr; ram_d[n_ram] = bus.ram_wrdata; end
                n_ram++;
            end
            if (bus.ctl_wr) begin
                if (n_ctl < 8) begin ctl_a[n_ctl] = bus.ctl_addr; ctl_d[n_ctl] = bus.ctl_wrdata; end
                n_ctl++;
            end
            if (bus.ctl_rd) n_rd++;
            if (done && done_cyc < 0) begin
                done_cyc = k; err_at_done = err; busy_at_done = busy;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic request(input logic s, input logic p, input logic [1:0] m, input logic [31:0] b);
        @(negedge clk);
        start = s; stop = p; mode = m; base_period = b;
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic check_cfg(input string tag, input logic [1:0] m, input logic [31:0] w0,
                             input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w [4];
        w = '{w0, w1, w2, w3};
        chk({tag, "_nram"}, n_ram, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), ram_a[i], {m, 2'(i)});
            chk($sformatf("%s_data%0d", tag, i), ram_d[i], w[i]);
        end
        chk({tag, "_nctl"}, n_ctl, 2);
        chk({tag, "_div_a"}, ctl_a[0], 1);
        chk({tag, "_div_d"}, ctl_d[0], {30'b0, m});
        chk({tag, "_run_a"}, ctl_a[1], 0);
        chk({tag, "_run_d"}, ctl_d[1], 1);
        chk({tag, "_nrd"}, n_rd, N_RD);
        chk({tag, "_done"}, done_cyc, DONE_CYC);
        chk({tag, "_busy_c1"}, busy_c1, 1);
        chk({tag, "_busy_done"}, busy_at_done, 0);
        chk({tag, "_viol"}, viol, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_strobes", {bus.ram_wr, bus.ctl_wr, bus.ctl_rd}, 0);
        chk("rst_data", {bus.ctl_addr, bus.ctl_wrdata, bus.ram_addr, bus.ram_wrdata}, 0);
        @(negedge clk);
        clr = 1'b0;

        request(1'b1, 1'b0, 2'd2, 32'd10);
        collect(12, 0, 1'b0);
        check_cfg("basic", 2'd2, 32'd40, 32'd10, 32'd10, 32'd40);
        chk("basic_err", err_at_done, 0);
        chk("basic_slave", {div_reg, run_reg}, {32'd2, 32'd1});

        request(1'b1, 1'b0, 2'd1, 32'hC000_0000);
        collect(12, 0, 1'b0);
        check_cfg("sat", 2'd1, 32'hFFFF_FFFF, 32'hC000_0000, 32'hC000_0000, 32'hFFFF_FFFF);

        request(1'b1, 1'b0, 2'd3, 32'h4000_0000);
        collect(12, 0, 1'b0);
        check_cfg("sat_edge", 2'd3, 32'hFFFF_FFFF, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF);

        request(1'b1, 1'b0, 2'd0, 32'h2000_0000);
        collect(12, 0, 1'b0);
        check_cfg("nosat", 2'd0, 32'h8000_0000, 32'h2000_0000, 32'h2000_0000, 32'h8000_0000);

        request(1'b1, 1'b0, 2'd3, 32'd0);
        collect(12, 0, 1'b0);
        check_cfg("zero", 2'd3, 32'd0, 32'd0, 32'd0, 32'd0);

        fault_run = 1'b1;
        request(1'b1, 1'b0, 2'd1, 32'd5);
        collect(12, 0, 1'b0);
        fault_run = 1'b0;
        chk("fault_err_done", err_at_done, RB);
        chk("fault_err_sticky", err, RB);
        chk("fault_done", done_cyc, DONE_CYC);
        request(1'b1, 1'b0, 2'd1, 32'd5);
        collect(12, 0, 1'b0);
        chk("fault_err_clear", err_c1, 0);
        chk("fault_err_done2", err_at_done, 0);

        request(1'b1, 1'b1, 2'd2, 32'd7);
        collect(8, 0, 1'b0);
        chk("ss_nram", n_ram, 0);
        chk("ss_nctl", n_ctl, 1);
        chk("ss_addr", ctl_a[0], 0);
        chk("ss_data", ctl_d[0], 0);
        chk("ss_done", done_cyc, 2);
        chk("ss_run", run_reg, 0);
        chk("ss_viol", viol, 0);

        request(1'b1, 1'b0, 2'd2, 32'd3);
        collect(16, 2, 1'b0);
        chk("busy_start_nram", n_ram, 4);
        chk("busy_start_nctl", n_ctl, 2);
        chk("busy_start_done", done_cyc, DONE_CYC);

        request(1'b1, 1'b0, 2'd2, 32'd3);
        collect(16, 3, 1'b1);
        chk("busy_stop_nctl", n_ctl, 2);
        chk("busy_stop_run", run_reg, 1);

        request(1'b1, 1'b0, 2'd1, 32'd9);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_pre", bus.ram_wr, 1);
        clr = 1'b1;
        #1;
        chk("midrst_strobes", {bus.ram_wr, bus.ctl_wr, bus.ctl_rd}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", bus.ram_addr, 0);
        @(negedge clk);
        clr = 1'b0;
        collect(12, 0, 1'b0);
        chk("midrst_nram", n_ram, 0);
        chk("midrst_nctl", n_ctl, 0);
        chk("midrst_done", done_cyc, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dec_cfg_master.md
# dec_cfg_master

Avalon-MM-style initiator that programs the semaphore decoder block through its control and memory slave ports. On a single `start` request it:
- computes the four per-colour period words from one base period;
- writes them into the decoder's period RAM;
- sets the divider and run registers;
- optionally reads the registers back to verify them.

It sits between the system controller (or a test harness) and the decoder, and replaces hand-sequenced bus writes.

## Interface
- `M`, 32, width of the period words and of `base_period`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to run the configure sequence.
- `stop`  in  1  one-cycle request to clear the decoder's run bit.
- `mode`  in  2  divider select; sampled with `start`.
- `base_period`  in  M  base period; sampled with `start`.
- `busy`  out  1  a sequence is in progress.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `err`  out  1  readback mismatch; sticky until the next accepted `start`.
- `ctl_wr`, `ctl_rd`  out  1  control-slave write and read strobes.
- `ctl_addr`  out  1  control register select: 0 = run, 1 = divider.
- `ctl_wrdata`  out  32  control write data.
- `ctl_rddata`  in  32  control read data; combinational in the slave, valid in the same cycle as `ctl_rd`.
- `ram_wr`  out  1  period RAM write strobe.
- `ram_addr`  out  4  RAM word index `{mode, contr}`.
- `ram_wrdata`  out  M  RAM write data.

## Operation
- **Colour codes (`contr`):** 0 red, 1 yellow, 2 red+yellow, 3 green.
- **Period shifts:** SHIFT = {2, 0, 0, 2}. Word `c` = `base_period << SHIFT[c]`.
  - If any set bit would be shifted out, the word saturates to all ones.
  - `base_period` = 0 produces 0 words and is legal.
- **States:**
  - IDLE: `busy` = 0.
  - WR_RAM: four cycles, `c` = 0..3.
  - WR_DIV.
  - WR_RUN.
  - RD_RUN.
  - RD_DIV.
  - FIN.
  - WR_STOP.
- **IDLE exits:**
  - `stop` goes to WR_STOP. If `start` and `stop` are asserted together, `stop` wins and `start` is dropped.
  - `start` alone latches `mode` and `base_period`, clears `err`, and goes to WR_RAM.
- **WR_RAM:** `ram_wr` = 1, `ram_addr` = `{mode, c}`, `ram_wrdata` = word `c`.
- **WR_DIV:** `ctl_wr` = 1, `ctl_addr` = 1, `ctl_wrdata` = `{30'b0, mode}`.
- **WR_RUN:** `ctl_wr` = 1, `ctl_addr` = 0, `ctl_wrdata` = 1.
- **RD_RUN:** `ctl_rd` = 1, `ctl_addr` = 0. Set `err` if `ctl_rddata[0]` ≠ 1.
- **RD_DIV:** `ctl_rd` = 1, `ctl_addr` = 1. Set `err` if `ctl_rddata[1:0]` ≠ `mode`.
- **FIN:** `done` = 1, then return to IDLE.
- **WR_STOP:** `ctl_wr` = 1, `ctl_addr` = 0, `ctl_wrdata` = 0, then FIN.
- **Requests while busy:** `start` and `stop` are ignored; no queueing.
- **Strobes:** `ctl_wr`, `ctl_rd` and `ram_wr` are mutually exclusive. When a strobe is inactive its address and data outputs hold 0.

## Timing
- All outputs are registered.
- **Reset values:** every output is 0 and the state is IDLE.
- **Reset mid-sequence:** all strobes drop asynchronously and no further access is issued.
- **Configure latency,** with `start` sampled at edge 0:
  - `busy` rises after edge 0.
  - RAM writes occupy cycles 1–4.
  - WR_DIV in cycle 5, WR_RUN in cycle 6.
  - RD_RUN in cycle 7, RD_DIV in cycle 8.
  - `done` in cycle 9; `busy` falls with `done`.
- **Stop latency:** WR_STOP in cycle 1, `done` in cycle 2.
- **Readback sampling:** `ctl_rddata` is captured at the rising edge that ends each RD cycle. `err` is visible from the following cycle and is guaranteed settled when `done` is high.
- **Throughput:** one bus access per cycle, no wait states. The slave accepts every strobe.

## Configuration
- **`DEC_CFG_READBACK_EN` defined:** RD_RUN and RD_DIV exist. `done` arrives in cycle 9 and `err` is functional.
- **Not defined:** WR_RUN goes straight to FIN, so `done` arrives in cycle 7. `err` is tied to 0 and `ctl_rd` is tied to 0.

## Structure
- **Package `dec_cfg_pkg`:**
  - state enum `cfg_state_t`;
  - `CTL_ADDR_RUN` = 0, `CTL_ADDR_DIV` = 1;
  - `contr` code constants;
  - the `SHIFT` array.
- **Sub-module `dec_period_calc`:** combinational shift-and-saturate, with inputs `base_period` and `c[1:0]`, and output a width-`M` word.
- **Top level:** FSM, input latches, registered bus outputs.

## Test plan
- **Reset:** assert `clr` mid-WR_RAM. All strobes drop to 0 immediately; no writes follow release.
- **Basic configure:** `start`, `mode` = 2, `base_period` = 10.
  - RAM writes at addresses 8, 9, 10, 11 with data 40, 10, 10, 40.
  - Divider write of 2, then run write of 1.
  - `done` in cycle 9 with `err` = 0 (readback build).
- **Saturation:** `base_period` = 0xC0000000. Words 0 and 3 are 0xFFFFFFFF; words 1 and 2 are 0xC0000000.
- **Readback fault:** slave model returns 0 for the run register. `err` = 1 at `done` and clears on the next `start`.
- **Simultaneous requests:** `start` and `stop` together in IDLE yields only a run = 0 write, with `done` in cycle 2. A `start` issued during `busy` is ignored, so exactly four RAM writes occur.
- **Without `DEC_CFG_READBACK_EN`:** `done` in cycle 7, and `ctl_rd` is never asserted.
